// File: rtl/vmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vmem_port_arbiter
// Purpose  : Shares one word-wide vector data memory port between the vector
//            core and the host loader. Each 4-lane (x,y,z,w) vector access
//            becomes four consecutive single-word accesses. Conflicting
//            requests are resolved round-robin. Load lanes are reassembled
//            into a 4*DW result that is presented with a one-cycle done pulse.
// Ports    : clk, rst (async, active-low)
//            c_* : core port  (req, we, addr, wdata in; gnt, done, rdata out)
//            h_* : host port  (identical to the core port)
//            m_* : memory port (en, we, addr, wdata out; rdata in, 1-cycle
//                  read latency)
//            busy: high whenever the sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module vmem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [AW-1:0]     c_addr,
    input  logic [4*DW-1:0]   c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [4*DW-1:0]   c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [AW-1:0]     h_addr,
    input  logic [4*DW-1:0]   h_wdata,
    output logic              h_gnt,
    output logic              h_done,
    output logic [4*DW-1:0]   h_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    input  logic [DW-1:0]     m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic c_OWNER_CORE = 1'b0;
    localparam logic c_OWNER_HOST = 1'b1;

    state_t                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [3:0][DW-1:0]    wdata_q, wdata_d;
    // Lanes 0..2 only: lane 3 arrives in RWAIT and goes straight to rdata.
    logic [2:0][DW-1:0]    shadow_q, shadow_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [4*DW-1:0]       c_rdata_q, c_rdata_d;
    logic [4*DW-1:0]       h_rdata_q, h_rdata_d;
    logic                  c_gnt_q, c_gnt_d, h_gnt_q, h_gnt_d;
    logic                  c_done_q, c_done_d, h_done_q, h_done_d;

    logic                  w_grant_host;
    logic [1:0]            w_lane_prev;
    logic                  w_acc;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        shadow_d     = shadow_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        c_rdata_d    = c_rdata_q;
        h_rdata_d    = h_rdata_q;
        c_gnt_d      = 1'b0;
        h_gnt_d      = 1'b0;
        c_done_d     = 1'b0;
        h_done_d     = 1'b0;
        w_grant_host = 1'b0;
        // Data visible now belongs to the access issued one cycle earlier.
        w_lane_prev  = lane_q - 2'd1;

        case (state_q)
            IDLE: begin
                if (c_req || h_req) begin
                    // Host wins only when alone or when the core was served last.
                    w_grant_host = h_req && (!c_req || (last_owner_q == c_OWNER_CORE));
                    owner_d = w_grant_host ? c_OWNER_HOST : c_OWNER_CORE;
                    we_d    = w_grant_host ? h_we    : c_we;
                    addr_d  = w_grant_host ? h_addr  : c_addr;
                    wdata_d = w_grant_host ? h_wdata : c_wdata;
                    lane_d  = 2'd0;
                    c_gnt_d = !w_grant_host;
                    h_gnt_d = w_grant_host;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (!we_q && (lane_q != 2'd0)) begin
                    shadow_d[w_lane_prev] = m_rdata;
                end
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    if (we_q) begin
                        state_d  = DONE;
                        c_done_d = (owner_q == c_OWNER_CORE);
                        h_done_d = (owner_q == c_OWNER_HOST);
                    end else begin
                        state_d = RWAIT;
                    end
                end
            end
            RWAIT: begin
                // Lane 3 data is merged on the same edge that raises done.
                state_d  = DONE;
                c_done_d = (owner_q == c_OWNER_CORE);
                h_done_d = (owner_q == c_OWNER_HOST);
                if (owner_q == c_OWNER_CORE) begin
                    c_rdata_d = {m_rdata, shadow_q[2], shadow_q[1], shadow_q[0]};
                end else begin
                    h_rdata_d = {m_rdata, shadow_q[2], shadow_q[1], shadow_q[0]};
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lane_q       <= 2'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            shadow_q     <= '0;
            owner_q      <= c_OWNER_CORE;
            last_owner_q <= c_OWNER_HOST;
            c_rdata_q    <= '0;
            h_rdata_q    <= '0;
            c_gnt_q      <= 1'b0;
            h_gnt_q      <= 1'b0;
            c_done_q     <= 1'b0;
            h_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            shadow_q     <= shadow_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            c_rdata_q    <= c_rdata_d;
            h_rdata_q    <= h_rdata_d;
            c_gnt_q      <= c_gnt_d;
            h_gnt_q      <= h_gnt_d;
            c_done_q     <= c_done_d;
            h_done_q     <= h_done_d;
        end
    end

    // Memory strobes decode the state register so reset removes them at once.
    assign w_acc   = (state_q == ACC);
    assign m_en    = w_acc;
    assign m_we    = w_acc & we_q;
    assign m_addr  = w_acc ? (addr_q + {{(AW-2){1'b0}}, lane_q}) : '0;
    assign m_wdata = w_acc ? wdata_q[lane_q] : '0;
    assign busy    = (state_q != IDLE);

    assign c_gnt   = c_gnt_q;
    assign h_gnt   = h_gnt_q;
    assign c_done  = c_done_q;
    assign h_done  = h_done_q;
    assign c_rdata = c_rdata_q;
    assign h_rdata = h_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmem_port_arbiter
// Purpose  : Directed self-checking bench for vmem_port_arbiter with a simple
//            word memory model (one-cycle read latency) on the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vmem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic              c_req, c_we, h_req, h_we;
    logic [AW-1:0]     c_addr, h_addr;
    logic [4*DW-1:0]   c_wdata, h_wdata;
    logic              c_gnt, c_done, h_gnt, h_done;
    logic [4*DW-1:0]   c_rdata, h_rdata;
    logic              m_en, m_we, busy;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata, m_rdata;

    logic [DW-1:0]     mem [256];
    logic [DW-1:0]     r_mrd;

    int total  = 0;
    int passed = 0;

    localparam logic [4*DW-1:0] c_VEC = {32'd40, 32'd30, 32'd20, 32'd10};

    vmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_done(h_done), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      r_mrd <= mem[m_addr];
        end
    end
    assign m_rdata = r_mrd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL idle_timeout busy=%0b required 0", busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++;
        if ({c_gnt, h_gnt, c_done, h_done, m_en, m_we, busy} !== 7'd0)
            $display("FAIL reset_ctrl got %b required 0000000",
                     {c_gnt, h_gnt, c_done, h_done, m_en, m_we, busy});
        else passed++;
        total++;
        if (m_addr !== 8'd0 || m_wdata !== 32'd0)
            $display("FAIL reset_mport addr=%0h wdata=%0h required 0/0", m_addr, m_wdata);
        else passed++;
        total++;
        if (c_rdata !== '0 || h_rdata !== '0)
            $display("FAIL reset_rdata c=%0h h=%0h required 0", c_rdata, h_rdata);
        else passed++;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_core_store();
        logic [DW-1:0] exp_w [4];
        exp_w = '{32'd10, 32'd20, 32'd30, 32'd40};
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'd4; c_wdata = c_VEC;
        step();  // T+1
        total++;
        if (c_gnt !== 1'b1 || h_gnt !== 1'b0)
            $display("FAIL store_gnt c_gnt=%0b h_gnt=%0b required 1/0", c_gnt, h_gnt);
        else passed++;
        c_req = 1'b0; c_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 8'(4 + k) || m_wdata !== exp_w[k])
                $display("FAIL store_lane%0d en=%0b we=%0b addr=%0h wdata=%0d required 1/1/%0h/%0d",
                         k, m_en, m_we, m_addr, m_wdata, 4 + k, exp_w[k]);
            else passed++;
            step();
        end
        // T+5
        total++;
        if (c_done !== 1'b1 || busy !== 1'b1)
            $display("FAIL store_done c_done=%0b busy=%0b required 1/1", c_done, busy);
        else passed++;
        step();  // T+6
        total++;
        if (busy !== 1'b0 || c_done !== 1'b0)
            $display("FAIL store_idle busy=%0b c_done=%0b required 0/0", busy, c_done);
        else passed++;
    endtask

    task automatic test_core_load();
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'd4; c_wdata = '1;
        step();  // T+1
        total++;
        if (c_gnt !== 1'b1) $display("FAIL load_gnt got %0b required 1", c_gnt);
        else passed++;
        c_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 8'(4 + k))
                $display("FAIL load_lane%0d en=%0b we=%0b addr=%0h required 1/0/%0h",
                         k, m_en, m_we, m_addr, 4 + k);
            else passed++;
            step();
        end
        // T+5
        total++;
        if (c_done !== 1'b0 || busy !== 1'b1)
            $display("FAIL load_rwait c_done=%0b busy=%0b required 0/1", c_done, busy);
        else passed++;
        step();  // T+6
        total++;
        if (c_done !== 1'b1 || c_rdata !== c_VEC)
            $display("FAIL load_done c_done=%0b c_rdata=%0h required 1/%0h", c_done, c_rdata, c_VEC);
        else passed++;
        total++;
        if (h_rdata !== '0) $display("FAIL load_h_rdata got %0h required 0", h_rdata);
        else passed++;
        wait_idle();
    endtask

    task automatic test_tie();
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h20; c_wdata = {4{32'hC0C0}};
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = {4{32'hB0B0}};
        step();
        rst = 1'b1;
        step();  // T+1
        total++;
        if (c_gnt !== 1'b1 || h_gnt !== 1'b0)
            $display("FAIL tie1_core c_gnt=%0b h_gnt=%0b required 1/0", c_gnt, h_gnt);
        else passed++;
        c_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (h_gnt !== 1'b0 || c_gnt !== 1'b0)
                $display("FAIL tie1_wait c_gnt=%0b h_gnt=%0b required 0/0", c_gnt, h_gnt);
            else passed++;
        end
        step();  // T+7
        total++;
        if (h_gnt !== 1'b1 || c_gnt !== 1'b0)
            $display("FAIL tie1_host c_gnt=%0b h_gnt=%0b required 0/1", c_gnt, h_gnt);
        else passed++;
        h_req = 1'b0;
        wait_idle();
        c_req = 1'b1; h_req = 1'b1;
        step();
        total++;
        if (c_gnt !== 1'b1 || h_gnt !== 1'b0)
            $display("FAIL tie2_core c_gnt=%0b h_gnt=%0b required 1/0", c_gnt, h_gnt);
        else passed++;
        c_req = 1'b0; h_req = 1'b0;
        wait_idle();
        c_req = 1'b1; h_req = 1'b1;
        step();
        total++;
        if (c_gnt !== 1'b0 || h_gnt !== 1'b1)
            $display("FAIL tie3_host c_gnt=%0b h_gnt=%0b required 0/1", c_gnt, h_gnt);
        else passed++;
        c_req = 1'b0; h_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'hFE; h_wdata = {32'h4, 32'h3, 32'h2, 32'h1};
        step();
        total++;
        if (h_gnt !== 1'b1) $display("FAIL wrap_gnt got %0b required 1", h_gnt);
        else passed++;
        h_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (m_en !== 1'b1 || m_addr !== exp_a[k] || m_wdata !== 32'(k + 1))
                $display("FAIL wrap_lane%0d en=%0b addr=%0h wdata=%0d required 1/%0h/%0d",
                         k, m_en, m_addr, m_wdata, exp_a[k], k + 1);
            else passed++;
            step();
        end
        total++;
        if (h_done !== 1'b1 || c_done !== 1'b0)
            $display("FAIL wrap_done h_done=%0b c_done=%0b required 1/0", h_done, c_done);
        else passed++;
        wait_idle();
    endtask

    task automatic test_held();
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h40; c_wdata = {4{32'h5A5A}};
        step();  // T+1
        total++;
        if (c_gnt !== 1'b1) $display("FAIL held_gnt1 got %0b required 1", c_gnt);
        else passed++;
        for (int i = 2; i <= 6; i++) begin
            step();
            total++;
            if (c_gnt !== 1'b0) $display("FAIL held_gap%0d c_gnt=%0b required 0", i, c_gnt);
            else passed++;
        end
        // T+6: idle sampling the still-high request, no access in flight
        total++;
        if (m_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL held_idle m_en=%0b busy=%0b required 0/0", m_en, busy);
        else passed++;
        step();  // T+7
        total++;
        if (c_gnt !== 1'b1 || m_addr !== 8'h40)
            $display("FAIL held_gnt2 c_gnt=%0b m_addr=%0h required 1/40", c_gnt, m_addr);
        else passed++;
        c_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_midop();
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'd4;
        step();  // T+1 lane 0
        c_req = 1'b0;
        step();  // lane 1
        step();  // lane 2
        total++;
        if (m_en !== 1'b1 || m_addr !== 8'd6)
            $display("FAIL midop_lane2 m_en=%0b m_addr=%0h required 1/6", m_en, m_addr);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (m_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL midop_async m_en=%0b busy=%0b required 0/0", m_en, busy);
        else passed++;
        total++;
        if (c_rdata !== '0) $display("FAIL midop_rdata got %0h required 0", c_rdata);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (c_done !== 1'b0) $display("FAIL midop_nodone got %0b required 0", c_done);
            else passed++;
        end
        rst = 1'b1;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd4;
        step();  // T+1
        total++;
        if (h_gnt !== 1'b1) $display("FAIL midop_hgnt got %0b required 1", h_gnt);
        else passed++;
        h_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (h_done !== 1'b0) $display("FAIL midop_hearly got %0b required 0", h_done);
        else passed++;
        step();  // T+6
        total++;
        if (h_done !== 1'b1 || h_rdata !== c_VEC || c_done !== 1'b0)
            $display("FAIL midop_hload h_done=%0b h_rdata=%0h c_done=%0b required 1/%0h/0",
                     h_done, h_rdata, c_done, c_VEC);
        else passed++;
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        r_mrd = '0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        test_reset();
        test_core_store();
        test_core_load();
        test_tie();
        test_wrap();
        test_held();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
